// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------
// arb_pkg : shared types, defaults and helpers for the RR arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_DEF        = 4;
  localparam int IDX_W_DEF    = 2;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W_DEF    = 3;
  localparam int OH_MAX_W     = 32;

  // OR of set-bit positions; exact for a one-hot or all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) idx |= int'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mask_encoder.sv
// ----------------------------------------------------------------
// rr_mask_encoder : circular priority encoder starting at ptr
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_mask_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
// ----------------------------------------------------------------
// rr_priority_arbiter : N-way round-robin arbiter with hold timeout
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] scan_ptr;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic             hold_last;
  logic             releasing;

  assign next_ptr  = grant_idx_q + IDX_W'(1);
  // Only the release edge in GRANT uses the rotated start point.
  assign scan_ptr  = (state_q == GRANT) ? next_ptr : ptr_q;
  assign hold_last = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign releasing = !req[grant_idx_q] || hold_last;

  rr_mask_encoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (req),
    .ptr   (scan_ptr),
    .found (found),
    .idx   (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          grant_d    = N'(1) << win_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (releasing) begin
          ptr_d      = next_ptr;
          timeout_d  = hold_last && req[grant_idx_q];
          hold_cnt_d = '0;
          if (found) begin
            grant_d = N'(1) << win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    grant_idx_d   = IDX_W'(onehot_to_idx(OH_MAX_W'(grant_d)));
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// ----------------------------------------------------------------
// tb_rr_priority_arbiter : model-checked bench over three hold limits
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] dg [3];
  logic [1:0] di [3];
  logic       dv [3];
  logic       dt [3];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_priority_arbiter u_dut8 (
    .clk (clk), .rst_n (rst_n), .req (req),
    .grant (dg[0]), .grant_idx (di[0]), .grant_valid (dv[0]), .timeout (dt[0])
  );

  rr_priority_arbiter #(.MAX_HOLD (4), .CNT_W (2)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .req (req),
    .grant (dg[1]), .grant_idx (di[1]), .grant_valid (dv[1]), .timeout (dt[1])
  );

  rr_priority_arbiter #(.MAX_HOLD (1), .CNT_W (1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .req (req),
    .grant (dg[2]), .grant_idx (di[2]), .grant_valid (dv[2]), .timeout (dt[2])
  );

  function automatic int hold_lim(input int j);
    case (j)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int winner(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: granted index (-1 idle), cycles shown so far, rotation start, timeout.
  int m_g   [3];
  int m_len [3];
  int m_ptr [3];
  bit m_to  [3];

  always @(posedge clk or negedge rst_n) begin : p_model
    int w;
    bit to;
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) begin
        m_g[j]   <= -1;
        m_len[j] <= 0;
        m_ptr[j] <= 0;
        m_to[j]  <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        to = 1'b0;
        if (m_g[j] < 0) begin
          w = winner(m_ptr[j], req);
          m_g[j]   <= w;
          m_len[j] <= (w >= 0) ? 1 : 0;
        end else if (!req[m_g[j]] || m_len[j] == hold_lim(j)) begin
          to = req[m_g[j]] && (m_len[j] == hold_lim(j));
          w  = winner((m_g[j] + 1) % 4, req);
          m_ptr[j] <= (m_g[j] + 1) % 4;
          m_g[j]   <= w;
          m_len[j] <= (w >= 0) ? 1 : 0;
        end else begin
          m_len[j] <= m_len[j] + 1;
        end
        m_to[j] <= to;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    int eg;
    if (rst_n) begin
      for (int j = 0; j < 3; j++) begin
        eg = (m_g[j] < 0) ? 0 : (1 << m_g[j]);
        check($sformatf("grant[%0d]", j),       int'(dg[j]), eg);
        check($sformatf("grant_idx[%0d]", j),   int'(di[j]), (m_g[j] < 0) ? 0 : m_g[j]);
        check($sformatf("grant_valid[%0d]", j), int'(dv[j]), (m_g[j] < 0) ? 0 : 1);
        check($sformatf("timeout[%0d]", j),     int'(dt[j]), int'(m_to[j]));
      end
    end
  end

  task automatic reset_pulse(input logic [3:0] next_req);
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req   = next_req;
  endtask

  initial begin : p_stim
    int exp3 [8];
    exp3 = '{1, 1, 2, 2, 4, 4, 8, 8};
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-grant clears outputs without waiting for a clock edge.
    req = 4'b0001;
    @(negedge clk);
    check("t1_grant_before_rst", int'(dg[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_grant_async",  int'(dg[0]), 0);
    check("t1_idx_async",    int'(di[0]), 0);
    check("t1_valid_async",  int'(dv[0]), 0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0010;
    @(negedge clk);
    check("t1_grant_after_rst", int'(dg[0]), 2);

    // Single request.
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check("t2_grant", int'(dg[0]), 4);
    check("t2_idx",   int'(di[0]), 2);
    check("t2_valid", int'(dv[0]), 1);
    check("t2_to",    int'(dt[0]), 0);
    req = 4'b0000;
    @(negedge clk);
    check("t2_grant_drop", int'(dg[0]), 0);
    check("t2_to_drop",    int'(dt[0]), 0);

    // All four request from reset, each leaves after two granted cycles.
    reset_pulse(4'b1111);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t3_grant_%0d", k), int'(dg[0]), exp3[k]);
      check($sformatf("t3_model_%0d", k), (m_g[0] < 0) ? 0 : (1 << m_g[0]), exp3[k]);
      if (k % 2 == 1) req = req & ~4'(exp3[k]);
    end
    @(negedge clk);
    check("t3_idle", int'(dg[0]), 0);

    // Lone requester held high: timeout pulses every 8 cycles, grant never drops.
    reset_pulse(4'b0001);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      check($sformatf("t4_grant_%0d", n), int'(dg[0]), 1);
      check($sformatf("t4_to_%0d", n),    int'(dt[0]), (n == 9 || n == 17) ? 1 : 0);
    end

    // Two requesters alternate every 4 cycles under the shorter hold limit.
    reset_pulse(4'b1001);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("t5_grant_%0d", n), int'(dg[1]), (((n - 1) / 4) % 2 == 0) ? 1 : 8);
      check($sformatf("t5_to_%0d", n),    int'(dt[1]), (n == 5 || n == 9) ? 1 : 0);
    end

    // Late arrival waits for the release, then rotation favours index 2.
    reset_pulse(4'b0001);
    @(negedge clk);
    check("t6_first", int'(dg[0]), 1);
    req = 4'b0011;
    repeat (3) @(negedge clk);
    check("t6_still0", int'(dg[0]), 1);
    req = 4'b0010;
    @(negedge clk);
    check("t6_handoff", int'(dg[0]), 2);
    req = 4'b0000;
    @(negedge clk);
    check("t6_idle", int'(dg[0]), 0);
    req = 4'b0101;
    @(negedge clk);
    check("t6_rotated", int'(dg[0]), 4);
    check("t6_rot_idx", int'(di[0]), 2);

    // Random-ish tail for extra model coverage.
    for (int n = 0; n < 60; n++) begin
      req = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Four-requester round-robin arbiter that shares a single resource, and is built around a rotating priority encoder.
- Grants exactly one requester at a time and reports the winner both one-hot and as a binary index. The binary index uses the same 2-bit index encoding as the team's 4:2 priority encoder.
- Bounds each grant with a hold timeout so that no requester can starve the others.
- Sits between the request sources and the shared datapath select/mux.

Parameters:
- N, 4, number of requesters; must be a power of two and >= 2.
- IDX_W, 2, width of grant_idx; equals log2(N).
- MAX_HOLD, 8, maximum number of consecutive cycles in one grant; must be >= 1.
- CNT_W, 3, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i is held high while requester i wants the resource.
- grant  output  N  one-hot grant; all zeros when idle.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high while any grant is asserted; equals |grant.
- timeout  output  1  one-cycle pulse after a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- All outputs are registered. No combinational path from req to grant.
- Winner selection: the first set bit of req scanning upward from index ptr, circularly (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- State IDLE:
  - If |req=0: stay in IDLE.
  - If |req=1 at a rising edge: go to GRANT. grant/grant_idx take the winner at that edge; hold_cnt=0.
  - Latency from req sampled to grant visible: 1 cycle.
- State GRANT (granted index g):
  - Release condition: req[g]=0, or hold_cnt==MAX_HOLD-1.
  - While not releasing: hold_cnt increments each cycle; grant is unchanged.
  - On the releasing edge:
    - ptr <= (g+1) mod N.
    - A new winner is computed from req at that same edge, scanning from (g+1) mod N.
    - If any req is set: grant the new winner in the very next cycle (back-to-back, no idle bubble); hold_cnt=0; stay in GRANT.
    - If no req is set: go to IDLE; grant=0.
- Timeout:
  - If the release was caused by hold_cnt reaching MAX_HOLD-1 while req[g] was still 1, timeout=1 for exactly the following cycle. Otherwise timeout=0.
  - A timed-out requester is still eligible. Being the lowest priority after rotation, it wins again only if no other request is set. In that case grant stays continuously high, but hold_cnt restarts at 0.
- MAX_HOLD=1: every grant lasts exactly one cycle, and arbitration occurs at every edge.
- Requests that arrive mid-grant are ignored until the release edge. Requests that drop before being granted are never granted.
- ptr updates only on a release edge; it does not change in IDLE.
- Grant duration is at most MAX_HOLD cycles.
- Invariant: grant is always zero or one-hot, and grant_idx is consistent with grant.

Decomposition:
- Package arb_pkg:
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Defaults for N, IDX_W and MAX_HOLD.
  - Function onehot_to_idx.
- Sub-module rr_mask_encoder:
  - Inputs: req, ptr. Outputs: found (1 bit), idx (IDX_W).
  - Purely combinational rotate-then-priority-encode.
- The top module holds the FSM, ptr, hold counter and output registers.

Test Plan:
1. Reset mid-grant: hold req=0001 until grant=0001, then pull rst_n=0 between edges → grant=0000, grant_idx=0, grant_valid=0 immediately, before the next edge. After release, req=0010 → grant=0010 one edge later.
2. Single request: req=0100 from IDLE → next edge grant=0100, grant_idx=2, grant_valid=1. Drop req → next edge grant=0000, with timeout=0 throughout.
3. Simultaneous requests from reset: req=1111, each requester drops its bit after 2 granted cycles → grants 0001, 0010, 0100, 1000, each lasting 2 cycles, back-to-back with no zero cycle between them.
4. Timeout, single requester, MAX_HOLD=8: req=0001 held high → first grant lasts exactly 8 cycles, then timeout=1 for one cycle while grant stays 0001 (re-grant). The next timeout pulse comes 8 cycles later.
5. Fairness, MAX_HOLD=4: req=1001 held high → 0001 for 4 cycles, 1000 for 4 cycles, 0001 for 4 cycles, and so on, with a timeout pulse at each switch.
6. Late arrival: grant=0001 active, req[1] rises, then req[0] drops 3 cycles later → grant=0010 on the next edge. ptr then equals 2, so a later req=0101 is granted 0100 first.
